// File: rtl/vta_host_csr_ctrl.sv
// Host CSR controller: sequences host DPI bridge requests onto a small CSR bank,
// issues the accelerator launch pulse, and tracks busy/done plus an execution cycle count.
//
// state | meaning
// IDLE  | waiting for a host request; dequeues it combinationally in the same cycle
// BLANK | one-cycle gap while the bridge's valid catches up; read response is presented here
module vta_host_csr_ctrl #(
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 32,
    parameter int NUM_CSR   = 8
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         host_req_valid,
    input  logic                         host_req_opcode,
    input  logic [ADDR_BITS-1:0]         host_req_addr,
    input  logic [DATA_BITS-1:0]         host_req_value,
    output logic                         host_req_deq,
    output logic                         host_resp_valid,
    output logic [DATA_BITS-1:0]         host_resp_bits,
    output logic                         accel_launch,
    input  logic                         accel_finish,
    output logic [NUM_CSR*DATA_BITS-1:0] csr_out
);
    localparam int IDX_BITS = $clog2(NUM_CSR);

    typedef enum logic {IDLE, BLANK} state_t;

    state_t                 state_q, state_d;
    logic                   busy_q, done_q, launch_q, rd_pend_q;
    logic [DATA_BITS-1:0]   cnt_q, resp_bits_q;
    logic [DATA_BITS-1:0]   gp_q [2:NUM_CSR-1];
    logic [DATA_BITS-1:0]   csr_view [NUM_CSR];

    logic                   addr_hit, wr_en, rd_en, launch_req;
    logic [IDX_BITS-1:0]    idx;
    logic [DATA_BITS-1:0]   rdata;

    assign idx      = host_req_addr[IDX_BITS+1:2];
    assign addr_hit = (host_req_addr[1:0] == 2'b00) &&
                      (host_req_addr[ADDR_BITS-1:IDX_BITS+2] == '0);

    // Architectural view of the bank; CSR0 bit0 (launch) always reads 0.
    always_comb begin
        csr_out = '0;
        for (int i = 0; i < NUM_CSR; i++) csr_view[i] = '0;
        csr_view[0][1] = done_q;
        csr_view[0][2] = busy_q;
        csr_view[1]    = cnt_q;
        for (int i = 2; i < NUM_CSR; i++) csr_view[i] = gp_q[i];
        for (int i = 0; i < NUM_CSR; i++) csr_out[i*DATA_BITS +: DATA_BITS] = csr_view[i];
    end

    assign rdata = addr_hit ? csr_view[idx] : '0;

    always_comb begin
        state_d      = state_q;
        host_req_deq = 1'b0;
        case (state_q)
            IDLE: begin
                if (host_req_valid && reset_n) begin
                    host_req_deq = 1'b1;
                    state_d      = BLANK;
                end
            end
            BLANK:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign wr_en      = host_req_deq && host_req_opcode && addr_hit;
    assign rd_en      = host_req_deq && !host_req_opcode;
    assign launch_req = wr_en && (idx == '0) && host_req_value[0] && !busy_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            launch_q    <= 1'b0;
            rd_pend_q   <= 1'b0;
            cnt_q       <= '0;
            resp_bits_q <= '0;
            for (int i = 2; i < NUM_CSR; i++) gp_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            launch_q  <= launch_req;
            rd_pend_q <= rd_en;
            if (rd_en) resp_bits_q <= rdata;
            // The finish edge itself is not counted.
            if (launch_req) begin
                busy_q <= 1'b1;
                done_q <= 1'b0;
                cnt_q  <= '0;
            end else if (busy_q) begin
                if (accel_finish) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
            for (int i = 2; i < NUM_CSR; i++) begin
                if (wr_en && (idx == IDX_BITS'(i))) gp_q[i] <= host_req_value;
            end
        end
    end

    // Gating with reset_n suppresses a response whose BLANK cycle is hit by reset.
    assign host_resp_valid = rd_pend_q && reset_n;
    assign host_resp_bits  = resp_bits_q;
    assign accel_launch    = launch_q;

endmodule

// File: tb/tb_vta_host_csr_ctrl.sv
// Directed bench for vta_host_csr_ctrl: reset, CSR read/write, launch/finish timing,
// stale-valid handling, address boundaries and mid-operation reset.
module tb_vta_host_csr_ctrl;
    logic         clock = 1'b0;
    logic         reset_n;
    logic         host_req_valid, host_req_opcode, accel_finish;
    logic [31:0]  host_req_addr, host_req_value;
    logic         host_req_deq, host_resp_valid, accel_launch;
    logic [31:0]  host_resp_bits;
    logic [255:0] csr_out;

    int checks = 0;
    int errors = 0;
    int launch_cnt = 0;
    logic [31:0] rd;

    vta_host_csr_ctrl #(.ADDR_BITS(32), .DATA_BITS(32), .NUM_CSR(8)) dut (
        .clock(clock), .reset_n(reset_n),
        .host_req_valid(host_req_valid), .host_req_opcode(host_req_opcode),
        .host_req_addr(host_req_addr), .host_req_value(host_req_value),
        .host_req_deq(host_req_deq), .host_resp_valid(host_resp_valid),
        .host_resp_bits(host_resp_bits), .accel_launch(accel_launch),
        .accel_finish(accel_finish), .csr_out(csr_out)
    );

    always #5 clock = ~clock;

    always @(posedge clock) if (accel_launch === 1'b1) launch_cnt++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] csr(input int i);
        return csr_out[i*32 +: 32];
    endfunction

    // Starts at a negedge in IDLE, returns at the negedge two cycles later (IDLE again).
    task automatic host_txn(input logic op, input logic [31:0] a, input logic [31:0] v,
                            input logic stale, output logic [31:0] rdata);
        host_req_valid = 1'b1; host_req_opcode = op; host_req_addr = a; host_req_value = v;
        #1 check_eq("deq_idle", {31'b0, host_req_deq}, 32'd1);
        @(negedge clock);
        if (!stale) host_req_valid = 1'b0;
        #1 check_eq("deq_blank", {31'b0, host_req_deq}, 32'd0);
        check_eq("resp_valid", {31'b0, host_resp_valid}, {31'b0, !op});
        rdata = host_resp_bits;
        @(negedge clock);
        host_req_valid = 1'b0;
    endtask

    initial begin
        int lc;
        reset_n = 1'b0; host_req_valid = 1'b1; host_req_opcode = 1'b0;
        host_req_addr = 32'h10; host_req_value = '0; accel_finish = 1'b0;

        // Reset held with valid asserted
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            #1 check_eq("rst_deq", {31'b0, host_req_deq}, 32'd0);
            check_eq("rst_resp", {31'b0, host_resp_valid}, 32'd0);
            check_eq("rst_launch", {31'b0, accel_launch}, 32'd0);
            check_eq("rst_csr", {31'b0, |csr_out}, 32'd0);
        end
        reset_n = 1'b1;
        host_txn(1'b0, 32'h10, 32'h0, 1'b0, rd);
        check_eq("rst_rd", rd, 32'h0);

        // Read/write of a general CSR
        host_txn(1'b1, 32'h08, 32'hDEADBEEF, 1'b0, rd);
        host_txn(1'b0, 32'h08, 32'h0, 1'b0, rd);
        check_eq("rw_rd", rd, 32'hDEADBEEF);
        check_eq("rw_csr2", csr(2), 32'hDEADBEEF);

        // Launch, then finish 10 cycles after the launch pulse
        lc = launch_cnt;
        host_req_valid = 1'b1; host_req_opcode = 1'b1; host_req_addr = 32'h0; host_req_value = 32'h1;
        @(negedge clock);
        host_req_valid = 1'b0;
        #1 check_eq("launch_hi", {31'b0, accel_launch}, 32'd1);
        @(negedge clock);
        #1 check_eq("launch_lo", {31'b0, accel_launch}, 32'd0);
        host_txn(1'b0, 32'h00, 32'h0, 1'b0, rd);
        check_eq("run_csr0", rd, 32'h4);
        repeat (7) @(negedge clock);
        accel_finish = 1'b1;
        @(negedge clock);
        accel_finish = 1'b0;
        #1 check_eq("fin_csr1", csr(1), 32'd10);
        check_eq("fin_csr0", csr(0), 32'h2);
        check_eq("launch_cnt", launch_cnt - lc, 32'd1);
        host_txn(1'b0, 32'h00, 32'h0, 1'b0, rd);
        check_eq("done_csr0", rd, 32'h2);
        host_txn(1'b0, 32'h04, 32'h0, 1'b0, rd);
        check_eq("done_csr1", rd, 32'd10);

        // Stale valid in BLANK, then back-to-back
        host_txn(1'b1, 32'h0C, 32'h55, 1'b1, rd);
        host_txn(1'b0, 32'h0C, 32'h0, 1'b0, rd);
        check_eq("stale_rd", rd, 32'h55);

        // Address boundaries
        host_txn(1'b0, 32'h20, 32'h0, 1'b0, rd);
        check_eq("oob_rd", rd, 32'h0);
        host_txn(1'b0, 32'h06, 32'h0, 1'b0, rd);
        check_eq("unal_rd", rd, 32'h0);
        host_txn(1'b1, 32'h04, 32'h12345678, 1'b0, rd);
        check_eq("ro_csr1", csr(1), 32'd10);
        host_txn(1'b1, 32'h0A, 32'h11111111, 1'b0, rd);
        check_eq("unal_wr", csr(2), 32'hDEADBEEF);

        // Launch while busy is ignored
        lc = launch_cnt;
        host_txn(1'b1, 32'h00, 32'h1, 1'b0, rd);
        #1 check_eq("busy_csr1_a", csr(1), 32'd1);
        host_txn(1'b1, 32'h00, 32'h1, 1'b0, rd);
        #1 check_eq("busy_csr1_b", csr(1), 32'd3);
        check_eq("busy_launch", launch_cnt - lc, 32'd1);
        accel_finish = 1'b1;
        @(negedge clock);
        accel_finish = 1'b0;
        #1 check_eq("fin2_csr1", csr(1), 32'd3);
        check_eq("fin2_csr0", csr(0), 32'h2);
        // Finish while idle
        accel_finish = 1'b1;
        @(negedge clock);
        accel_finish = 1'b0;
        #1 check_eq("idle_fin_csr0", csr(0), 32'h2);
        check_eq("idle_fin_csr1", csr(1), 32'd3);

        // Reset during BLANK of a read while busy
        host_txn(1'b1, 32'h00, 32'h1, 1'b0, rd);
        check_eq("mid_busy", csr(0), 32'h4);
        host_req_valid = 1'b1; host_req_opcode = 1'b0; host_req_addr = 32'h08;
        #1 check_eq("mid_deq", {31'b0, host_req_deq}, 32'd1);
        @(negedge clock);
        host_req_valid = 1'b0;
        reset_n = 1'b0;
        #1 check_eq("mid_resp", {31'b0, host_resp_valid}, 32'd0);
        @(negedge clock);
        #1 check_eq("mid_resp2", {31'b0, host_resp_valid}, 32'd0);
        check_eq("mid_csr0", csr(0), 32'h0);
        check_eq("mid_csr1", csr(1), 32'h0);
        check_eq("mid_launch", {31'b0, accel_launch}, 32'd0);
        reset_n = 1'b1;
        host_txn(1'b0, 32'h08, 32'h0, 1'b0, rd);
        check_eq("mid_csr2", rd, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
